mem_access_stage: RTL and testbench

- MEM pipeline stage between execute and writeback; the sole master of the byte-addressed data memory (2048 x 8, big-endian word pairs, combinational read, write on clock falling edge).
- Accepts one load/store/pass-through op per cycle under valid/ready.
- Generates memory strobes, extracts and extends bytes, checks bounds, and registers the result toward writeback.
- Keeps saturating load/store/fault counters.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_access_stage_sat_counter.sv | 32 +++
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory geometry, access mode
// encodings, op classification and the byte-extend helper.
package mem_pkg;

  localparam int MEM_BYTES = 2048;
  localparam int WORD_W    = 16;

  localparam logic MODE_WORD = 1'b0;
  localparam logic MODE_BYTE = 1'b1;

  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_kind_e;

  // Widen a loaded byte to a full word, replicating bit 7 when sext is set.
  function automatic logic [WORD_W-1:0] byte_extend(input logic [7:0] b,
                                                    input logic       sext);
    logic [WORD_W-1:0] r;
    r = {{(WORD_W-8){sext & b[7]}}, b};
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_sat_counter.sv
// Saturating up-counter used for the load/store/fault statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data memory strobes, bounds-checks the
// access, extends byte loads and registers the result toward writeback.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = mem_pkg::MEM_BYTES,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_byte,
  input  logic              ex_sext,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [2:0]        ex_dest,
  input  logic              ex_reg_we,

  output logic              mem_rd,
  output logic              mem_wn,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  input  logic              wb_stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        wb_dest,
  output logic              wb_we,
  output logic              wb_fault,

  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_store,
  output logic [CNT_W-1:0]  cnt_fault
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 2);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);

  op_kind_e          op_kind;
  logic              addr_ok;
  logic              in_range;
  logic              fault;
  logic              accept;

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic [2:0]        wb_dest_q,  wb_dest_d;
  logic              wb_we_q,    wb_we_d;
  logic              wb_fault_q, wb_fault_d;

  // Handshake: an op transfers on a rising edge when ex_valid && ex_ready.
  // ex_ready drops only while a valid result is held by a stalled writeback;
  // ex_valid and the ex_* fields must stay stable until the transfer.
  assign ex_ready = !wb_valid_q || !wb_stall;
  assign accept   = ex_valid && ex_ready && !rst;

  always_comb begin
    op_kind = OP_PASS;
    if (ex_is_load) begin
      op_kind = OP_LOAD;
    end else if (ex_is_store) begin
      op_kind = OP_STORE;
    end
  end

  // A word touches a and a+1, so its last legal start is one byte earlier.
  assign addr_ok  = ex_byte ? (ex_addr <= LAST_BYTE) : (ex_addr <= LAST_WORD);
  assign in_range = (op_kind == OP_PASS) || addr_ok;
  assign fault    = !in_range;

  // Strobes only in the accept cycle, so a stall never replays a store.
  assign mem_rd    = accept && in_range && (op_kind == OP_LOAD);
  assign mem_wn    = accept && in_range && (op_kind == OP_STORE);
  assign mem_mode  = ex_byte ? MODE_BYTE : MODE_WORD;
  assign mem_addr  = ex_addr;
  assign mem_wdata = ex_wdata;

  always_comb begin
    wb_data_d  = '0;
    wb_we_d    = 1'b0;
    wb_dest_d  = ex_dest;
    wb_fault_d = fault;
    wb_valid_d = 1'b1;
    if (!fault) begin
      case (op_kind)
        OP_LOAD: begin
          wb_we_d = ex_reg_we;
          if (ex_byte) begin
            wb_data_d = DATA_W'(byte_extend(mem_rdata[DATA_W-1:DATA_W-8], ex_sext));
          end else begin
            wb_data_d = mem_rdata;
          end
        end
        OP_STORE: begin
          wb_data_d = '0;
          wb_we_d   = 1'b0;
        end
        default: begin
          wb_data_d = DATA_W'(ex_addr);
          wb_we_d   = ex_reg_we;
        end
      endcase
    end
  end

  // Result register: load on accept, retire when writeback drains, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_fault_q <= 1'b0;
    end else if (accept) begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dest_q  <= wb_dest_d;
      wb_we_q    <= wb_we_d;
      wb_fault_q <= wb_fault_d;
    end else if (!wb_stall) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_dest  = wb_dest_q;
  assign wb_we    = wb_we_q;
  assign wb_fault = wb_fault_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_load (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_rd),
    .count (cnt_load)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_store (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_wn),
    .count (cnt_store)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_fault (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && fault),
    .count (cnt_fault)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 2048-byte big-endian memory
// fixture (combinational read, falling-edge write).
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_byte, ex_sext;
  logic [15:0] ex_addr, ex_wdata;
  logic [2:0]  ex_dest;
  logic        ex_reg_we;
  logic        mem_rd, mem_wn, mem_mode;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_stall, wb_valid, wb_we, wb_fault;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic [15:0] cnt_load, cnt_store, cnt_fault;

  logic [7:0]  mem [0:2047];
  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_byte(ex_byte), .ex_sext(ex_sext),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_dest(ex_dest),
    .ex_reg_we(ex_reg_we),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_we(wb_we), .wb_fault(wb_fault),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_fault(cnt_fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory fixture: reads 0 unless strobed; bytes past the end read 0.
  always_comb begin
    mem_rdata = '0;
    if (mem_rd && int'(mem_addr) < 2048) begin
      mem_rdata[15:8] = mem[int'(mem_addr)];
      if (int'(mem_addr) + 1 < 2048) mem_rdata[7:0] = mem[int'(mem_addr) + 1];
    end
  end

  always @(negedge clk) begin
    if (mem_wn && int'(mem_addr) < 2048) begin
      if (mem_mode) begin
        mem[int'(mem_addr)] <= mem_wdata[7:0];
      end else begin
        mem[int'(mem_addr)] <= mem_wdata[15:8];
        if (int'(mem_addr) + 1 < 2048) mem[int'(mem_addr) + 1] <= mem_wdata[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic st,
                        input logic by, input logic sx,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [2:0] dest, input logic we);
    ex_valid    = v;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_byte     = by;
    ex_sext     = sx;
    ex_addr     = addr;
    ex_wdata    = wdata;
    ex_dest     = dest;
    ex_reg_we   = we;
  endtask

  task automatic set_idle();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst      = 1'b1;
    wb_stall = 1'b0;
    set_idle();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_cnt_load", 32'(cnt_load), 32'd0);

    // Word store then word load
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3'd1, 1'b0);
    #1;
    chk("st_mem_wn", 32'(mem_wn), 32'd1);
    chk("st_mem_rd", 32'(mem_rd), 32'd0);
    step();
    chk("st_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_wb_we", 32'(wb_we), 32'd0);
    chk("st_cnt_store", 32'(cnt_store), 32'd1);
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd3, 1'b1);
    #1;
    chk("ld_mem_rd", 32'(mem_rd), 32'd1);
    chk("ld_mem_wn", 32'(mem_wn), 32'd0);
    step();
    chk("ld_wb_data", 32'(wb_data), 32'hBEEF);
    chk("ld_wb_we", 32'(wb_we), 32'd1);
    chk("ld_wb_dest", 32'(wb_dest), 32'd3);
    chk("ld_cnt_load", 32'(cnt_load), 32'd1);

    // Byte store, then sign- and zero-extended byte loads
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0080, 3'd0, 1'b0);
    step();
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd2, 1'b1);
    step();
    chk("lb_sext", 32'(wb_data), 32'hFF80);
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 3'd2, 1'b1);
    step();
    chk("lb_zext", 32'(wb_data), 32'h0080);

    // Bounds: word at 0x07FF, byte at 0x0800 fault; byte at 0x07FF is fine
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h07FF, 16'h0000, 3'd4, 1'b1);
    #1;
    chk("oob_word_rd", 32'(mem_rd), 32'd0);
    step();
    chk("oob_word_fault", 32'(wb_fault), 32'd1);
    chk("oob_word_we", 32'(wb_we), 32'd0);
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0011, 3'd0, 1'b0);
    #1;
    chk("oob_byte_wn", 32'(mem_wn), 32'd0);
    step();
    chk("oob_byte_fault", 32'(wb_fault), 32'd1);
    chk("oob_cnt_fault", 32'(cnt_fault), 32'd2);
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h07FF, 16'h005A, 3'd0, 1'b0);
    #1;
    chk("edge_byte_wn", 32'(mem_wn), 32'd1);
    step();
    chk("edge_st_fault", 32'(wb_fault), 32'd0);
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h07FF, 16'h0000, 3'd6, 1'b1);
    step();
    chk("edge_lb_data", 32'(wb_data), 32'h005A);
    chk("edge_lb_fault", 32'(wb_fault), 32'd0);
    chk("cnt_load_4", 32'(cnt_load), 32'd4);
    chk("cnt_store_3", 32'(cnt_store), 32'd3);
    chk("cnt_fault_2", 32'(cnt_fault), 32'd2);

    // Store then 3 stall cycles with the store still presented
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h1234, 3'd0, 1'b0);
    #1;
    chk("stall_st_wn", 32'(mem_wn), 32'd1);
    step();
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", 32'(ex_ready), 32'd0);
      chk("stall_wn", 32'(mem_wn), 32'd0);
      chk("stall_valid", 32'(wb_valid), 32'd1);
      chk("stall_data", 32'(wb_data), 32'h0000);
      step();
    end
    chk("stall_cnt_store", 32'(cnt_store), 32'd4);
    wb_stall = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0AAA, 16'h0000, 3'd5, 1'b1);
    #1;
    chk("release_ready", 32'(ex_ready), 32'd1);
    step();
    chk("release_data", 32'(wb_data), 32'h0AAA);
    chk("release_dest", 32'(wb_dest), 32'd5);

    // Back-to-back pass-through ops
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 3'd1, 1'b1);
    exp_q.push_back(16'h1234);
    step();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5678, 16'h0000, 3'd2, 1'b1);
    exp_q.push_back(16'h5678);
    chk("b2b_data0", 32'(wb_data), 32'(exp_q.pop_front()));
    step();
    set_idle();
    chk("b2b_data1", 32'(wb_data), 32'(exp_q.pop_front()));
    chk("b2b_valid1", 32'(wb_valid), 32'd1);
    step();
    chk("b2b_drain_valid", 32'(wb_valid), 32'd0);
    chk("b2b_drain_hold", 32'(wb_data), 32'h5678);

    // Reset mid-stream with a store presented
    rst = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hDEAD, 3'd0, 1'b0);
    #1;
    chk("rst_st_wn", 32'(mem_wn), 32'd0);
    step();
    rst = 1'b0;
    set_idle();
    #1;
    chk("rst2_valid", 32'(wb_valid), 32'd0);
    chk("rst2_data", 32'(wb_data), 32'h0);
    chk("rst2_cnt_store", 32'(cnt_store), 32'd0);
    chk("rst2_cnt_load", 32'(cnt_load), 32'd0);
    chk("rst2_cnt_fault", 32'(cnt_fault), 32'd0);
    chk("rst2_ready", 32'(ex_ready), 32'd1);
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 3'd7, 1'b1);
    step();
    set_idle();
    chk("rst2_store_dropped", 32'(wb_data), 32'h0000);
    chk("rst2_ld_valid", 32'(wb_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
